// File: rtl/demux1x4_dispatch.sv
// Registered 1-to-4 stream dispatcher: one valid/ready producer feeds four
// single-entry output slots, each with its own handshake and a delivery counter.
module demux1x4_dispatch #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [4*CNT_W-1:0]  out_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  logic [3:0] vld;
  logic       acc;

  // A full slot that drains this cycle can take the next word in the same cycle.
  always_comb begin
    in_ready = rst_n & (~vld[in_sel] | out_ready[in_sel]);
    acc      = in_valid & in_ready;
  end

  assign out_valid = vld;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      slot_state_e       state_q, state_d;
      logic [DATA_W-1:0] data_q, data_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic              acc_k;
      logic              drn_k;

      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        acc_k   = acc & (in_sel == 2'(gi));
        drn_k   = (state_q == ST_FULL) & out_ready[gi];
        case (state_q)
          ST_EMPTY: begin
            if (acc_k) begin
              state_d = ST_FULL;
              data_d  = in_data;
            end
          end
          ST_FULL: begin
            if (drn_k) begin
              cnt_d = cnt_q + 1'b1;
              if (acc_k) data_d = in_data;
              else       state_d = ST_EMPTY;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= ST_EMPTY;
          data_q  <= '0;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
          cnt_q   <= cnt_d;
        end
      end

      assign vld[gi]                       = (state_q == ST_FULL);
      assign out_data[gi*DATA_W +: DATA_W] = data_q;
      assign out_cnt[gi*CNT_W +: CNT_W]    = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_demux1x4_dispatch.sv
// Self-checking bench for demux1x4_dispatch: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_demux1x4_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [31:0] out_cnt;

  demux1x4_dispatch #(.DATA_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each slot is a queue of at most one pending word.
  logic [7:0] m_q[4][$];
  logic [7:0] m_cnt[4];

  typedef struct {
    logic       rst_n;
    logic       in_valid;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_q[k].delete();
      m_cnt[k] = 8'd0;
    end
  endtask

  // One clock cycle: apply inputs, check in_ready and deliveries, advance, check outputs.
  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] o, output logic rdy_seen);
    logic exp_rdy;
    rst_n = r; in_valid = v; in_sel = s; in_data = d; out_ready = o;
    #1;
    rdy_seen = in_ready;
    exp_rdy  = r && (m_q[s].size() == 0 || o[s]);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (!r) begin
      model_clear();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_q[k].size() > 0 && o[k]) begin
          chk($sformatf("delivered_data%0d", k), {56'd0, out_data[k*8 +: 8]}, {56'd0, m_q[k][0]});
          void'(m_q[k].pop_front());
          m_cnt[k] = m_cnt[k] + 8'd1;
        end
      end
      if (v && exp_rdy) m_q[s].push_back(d);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid%0d", k), {63'd0, out_valid[k]}, {63'd0, (m_q[k].size() > 0)});
      if (m_q[k].size() > 0)
        chk($sformatf("out_data%0d", k), {56'd0, out_data[k*8 +: 8]}, {56'd0, m_q[k][0]});
      chk($sformatf("out_cnt%0d", k), {56'd0, out_cnt[k*8 +: 8]}, {56'd0, m_cnt[k]});
    end
  endtask

  initial begin
    logic rdy;
    logic p_v;
    logic [1:0] p_s;
    logic [7:0] p_d;
    logic r;

    tbl[0] = '{1'b0, 1'b1, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b0000};
    tbl[1] = '{1'b0, 1'b1, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b0000};
    tbl[2] = '{1'b1, 1'b1, 2'd0, 8'hA0, 4'b0000, 1'b1, 4'b0001};
    tbl[3] = '{1'b1, 1'b1, 2'd1, 8'hA1, 4'b0000, 1'b1, 4'b0011};
    tbl[4] = '{1'b1, 1'b1, 2'd2, 8'hA2, 4'b0000, 1'b1, 4'b0111};
    tbl[5] = '{1'b1, 1'b1, 2'd3, 8'hA3, 4'b0000, 1'b1, 4'b1111};
    tbl[6] = '{1'b1, 1'b1, 2'd2, 8'hA4, 4'b0000, 1'b0, 4'b1111};

    model_clear();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rst_n, tbl[i].in_valid, tbl[i].sel, tbl[i].data, tbl[i].ordy, rdy);
      chk($sformatf("tbl%0d_in_ready", i), {63'd0, rdy}, {63'd0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d_out_valid", i), {60'd0, out_valid}, {60'd0, tbl[i].exp_ov});
      if (i == 1) begin
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_cnt", {32'd0, out_cnt}, 64'd0);
      end
    end
    chk("route_data", {32'd0, out_data}, {32'd0, 32'hA3A2A1A0});
    step(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, rdy);
    chk("route_drain_cnt", {32'd0, out_cnt}, {32'd0, 32'h01010101});

    // Streaming to channel 1 with its consumer always ready.
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, rdy);
    chk("post_rst_valid", {60'd0, out_valid}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 2'd1, 8'(i), 4'b0010, rdy);
      chk("stream_in_ready", {63'd0, rdy}, 64'd1);
      chk("stream_out", {56'd0, out_data[15:8]}, {56'd0, 8'(i)});
    end
    step(1'b1, 1'b0, 2'd1, 8'h00, 4'b0010, rdy);
    chk("stream_cnt1", {56'd0, out_cnt[15:8]}, 64'd16);

    // Simultaneous drain and refill on channel 3.
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, rdy);
    step(1'b1, 1'b1, 2'd3, 8'h55, 4'b0000, rdy);
    step(1'b1, 1'b1, 2'd3, 8'h66, 4'b1000, rdy);
    chk("refill_in_ready", {63'd0, rdy}, 64'd1);
    chk("refill_valid3", {63'd0, out_valid[3]}, 64'd1);
    chk("refill_data3", {56'd0, out_data[31:24]}, 64'h66);
    chk("refill_cnt3", {56'd0, out_cnt[31:24]}, 64'd1);

    // Counter wrap on channel 0 after 257 deliveries.
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, rdy);
    for (int i = 0; i < 257; i++) step(1'b1, 1'b1, 2'd0, 8'(i * 3), 4'b0001, rdy);
    step(1'b1, 1'b0, 2'd0, 8'h00, 4'b0001, rdy);
    chk("wrap_cnt0", {56'd0, out_cnt[7:0]}, 64'd1);
    chk("wrap_cnt_others", {40'd0, out_cnt[31:8]}, 64'd0);

    // Reset mid-operation discards words and any coinciding delivery.
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, rdy);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'd2, 8'(8'h20 + i), 4'b0100, rdy);
    step(1'b1, 1'b0, 2'd2, 8'h00, 4'b0100, rdy);
    chk("mid_cnt2", {56'd0, out_cnt[23:16]}, 64'd5);
    step(1'b1, 1'b1, 2'd2, 8'h77, 4'b0000, rdy);
    step(1'b1, 1'b1, 2'd0, 8'h88, 4'b0000, rdy);
    chk("mid_full", {60'd0, out_valid}, 64'b0101);
    step(1'b0, 1'b1, 2'd1, 8'h99, 4'b1111, rdy);
    chk("mid_rst_valid", {60'd0, out_valid}, 64'd0);
    chk("mid_rst_cnt", {32'd0, out_cnt}, 64'd0);
    step(1'b1, 1'b0, 2'd3, 8'h00, 4'b0000, rdy);
    chk("mid_release_ready", {63'd0, rdy}, 64'd1);

    // Randomized traffic obeying the producer hold rule.
    p_v = 1'b0; p_s = 2'd0; p_d = 8'd0;
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 199) != 0);
      if (!p_v && $urandom_range(0, 3) != 0) begin
        p_v = 1'b1;
        p_s = 2'($urandom_range(0, 3));
        p_d = 8'($urandom);
      end
      step(r, p_v, p_s, p_d, 4'($urandom), rdy);
      if (p_v && rdy) p_v = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
